// File: rtl/fp8_pkg.sv
// Shared fp8 (1s/4e/3m) definitions for the adder arbiter and its picker.
package fp8_pkg;
   localparam int FP8_W        = 8;
   localparam int FP8_EXP_W    = 4;
   localparam int FP8_MANT_W   = 3;
   localparam int FP8_SIGN_POS = 7;
   localparam int FP8_EXP_LSB  = 3;
   localparam int FP8_MANT_LSB = 0;
   localparam int FP8_MAX_REQ  = 8;
   localparam int FP8_IDX_W    = 3;

   typedef struct packed {
      logic                  sign;
      logic [FP8_EXP_W-1:0]  expo;
      logic [FP8_MANT_W-1:0] mant;
   } fp8_t;

   function automatic fp8_t fp8_from_bits(input logic [FP8_W-1:0] v);
      fp8_t r;
      r.sign = v[FP8_SIGN_POS];
      r.expo = v[FP8_EXP_LSB +: FP8_EXP_W];
      r.mant = v[FP8_MANT_LSB +: FP8_MANT_W];
      return r;
   endfunction
endpackage

// File: rtl/fp8_rr_pick.sv
// Combinational round-robin picker: search starts just after ptr and wraps.
module fp8_rr_pick
   import fp8_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible,
   input  logic [FP8_IDX_W-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [FP8_IDX_W-1:0] grant_idx,
   output logic                 grant_any
);
   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_any && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = FP8_IDX_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fp8_add_arbiter.sv
// Round-robin sharing of one pipelined fp8 adder among NUM_REQ requesters.
// Define FP8_ARB_STATS_EN to build the 16-bit issued-operation counter.
module fp8_add_arbiter
   import fp8_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDER_LAT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [8*NUM_REQ-1:0] req_a,
   input  logic [8*NUM_REQ-1:0] req_b,
   input  logic                 pause,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [7:0]           rsp_data,
   output logic [7:0]           add_a,
   output logic [7:0]           add_b,
   output logic                 add_en,
   input  logic [7:0]           add_res,
   output logic                 idle,
   output logic [15:0]          stat_ops
);
   genvar gi;

   logic [NUM_REQ-1:0]   outstanding_q, outstanding_d;
   logic [FP8_IDX_W-1:0] ptr_q, ptr_d;
   fp8_t                 add_a_q, add_a_d, add_b_q, add_b_d;
   logic                 add_en_q, add_en_d;
   logic [FP8_IDX_W-1:0] issue_idx_q, issue_idx_d;
   logic [ADDER_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [FP8_IDX_W-1:0] tag_idx_q [ADDER_LAT];
   logic [FP8_IDX_W-1:0] tag_idx_d [ADDER_LAT];

   logic [NUM_REQ-1:0]   eligible, grant;
   logic [FP8_IDX_W-1:0] grant_idx;
   logic                 grant_any;
   logic [7:0]           sel_a, sel_b;
   logic                 tail_vld;
   logic [FP8_IDX_W-1:0] tail_idx;

   // Reset is folded into eligibility so no handshake can occur while held in reset.
   assign eligible = req_valid & ~outstanding_q & {NUM_REQ{~pause & rst_n}};

   fp8_rr_pick #(.N(NUM_REQ)) u_pick (
      .eligible  (eligible),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[8*i +: 8];
            sel_b = req_b[8*i +: 8];
         end
      end
   end

   // Tag stage 0 is loaded from the issue register, so the tail lines up with add_res.
   assign tail_vld = tag_vld_q[ADDER_LAT-1];
   assign tail_idx = tag_idx_q[ADDER_LAT-1];

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
         assign rsp_valid[gi] = tail_vld && (tail_idx == FP8_IDX_W'(gi));
      end
   endgenerate

   assign rsp_data = tail_vld ? add_res : 8'h00;

   always_comb begin
      outstanding_d = (outstanding_q & ~rsp_valid) | grant;
      ptr_d         = grant_any ? grant_idx : ptr_q;
      add_a_d       = grant_any ? fp8_from_bits(sel_a) : add_a_q;
      add_b_d       = grant_any ? fp8_from_bits(sel_b) : add_b_q;
      add_en_d      = grant_any;
      issue_idx_d   = grant_any ? grant_idx : issue_idx_q;
      tag_vld_d[0]  = add_en_q;
      tag_idx_d[0]  = issue_idx_q;
      for (int k = 1; k < ADDER_LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_idx_d[k] = tag_idx_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outstanding_q <= '0;
         ptr_q         <= FP8_IDX_W'(NUM_REQ - 1);
         add_a_q       <= '0;
         add_b_q       <= '0;
         add_en_q      <= 1'b0;
         issue_idx_q   <= '0;
         tag_vld_q     <= '0;
         for (int k = 0; k < ADDER_LAT; k++) tag_idx_q[k] <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         ptr_q         <= ptr_d;
         add_a_q       <= add_a_d;
         add_b_q       <= add_b_d;
         add_en_q      <= add_en_d;
         issue_idx_q   <= issue_idx_d;
         tag_vld_q     <= tag_vld_d;
         for (int k = 0; k < ADDER_LAT; k++) tag_idx_q[k] <= tag_idx_d[k];
      end
   end

   assign add_a  = add_a_q;
   assign add_b  = add_b_q;
   assign add_en = add_en_q;
   assign idle   = ~(|outstanding_q) & ~add_en_q;

`ifdef FP8_ARB_STATS_EN
   logic [15:0] stat_q, stat_d;

   always_comb stat_d = grant_any ? stat_q + 16'd1 : stat_q;

   always_ff @(posedge clk) begin
      if (!rst_n) stat_q <= '0;
      else        stat_q <= stat_d;
   end

   assign stat_ops = stat_q;
`else
   assign stat_ops = 16'h0000;
`endif
endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Directed bench for fp8_add_arbiter; the stub adder returns add_a^add_b after ADDER_LAT cycles.
module tb_fp8_add_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int ADDER_LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready, rsp_valid;
   logic [31:0] req_a, req_b;
   logic        pause, add_en, idle;
   logic [7:0]  rsp_data, add_a, add_b, add_res;
   logic [15:0] stat_ops;
   logic [7:0]  stub_q [ADDER_LAT];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      stub_q[0] <= add_a ^ add_b;
      for (int k = 1; k < ADDER_LAT; k++) stub_q[k] <= stub_q[k-1];
   end
   assign add_res = stub_q[ADDER_LAT-1];

   fp8_add_arbiter #(.NUM_REQ(NUM_REQ), .ADDER_LAT(ADDER_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .pause     (pause),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_en    (add_en),
      .add_res   (add_res),
      .idle      (idle),
      .stat_ops  (stat_ops)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] t2_a [4];
   logic [7:0] t2_r [4];
   int hs;
   int cyc;

   initial begin
      t2_a = '{8'h11, 8'h22, 8'h33, 8'h44};
      t2_r = '{8'h10, 8'h20, 8'h30, 8'h40};

      // Reset state, with requests asserted to prove gating
      rst_n = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0; pause = 1'b0;
      repeat (3) tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      chk("rst_add_en", 32'(add_en), 32'h0);
      chk("rst_add_a", 32'(add_a), 32'h0);
      chk("rst_add_b", 32'(add_b), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      chk("rst_stat", 32'(stat_ops), 32'h0);
      req_valid = 4'h0; rst_n = 1'b1;
      tick();
      $display("reset checks done");

      // 1: single request
      req_a[7:0] = 8'h38; req_b[7:0] = 8'h41; req_valid = 4'b0001;
      #1 chk("t1_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 4'h0;
      chk("t1_add_en", 32'(add_en), 32'h1);
      chk("t1_add_a", 32'(add_a), 32'h38);
      chk("t1_add_b", 32'(add_b), 32'h41);
      chk("t1_busy", 32'(idle), 32'h0);
      tick(); chk("t1_add_en_drop", 32'(add_en), 32'h0);
      tick(); chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_data", 32'(rsp_data), 32'h79);
      tick();
      chk("t1_idle", 32'(idle), 32'h1);
      chk("t1_rsp_gone", 32'(rsp_valid), 32'h0);
      $display("test1 single request done");

      // 2: all four valid from reset
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req_a = 32'h44332211; req_b = 32'h04030201; req_valid = 4'hF;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_ready", 32'(req_ready), 32'(1 << i));
         tick();
         chk("t2_add_a", 32'(add_a), 32'(t2_a[i]));
      end
      req_valid = 4'h0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_rsp_valid", 32'(rsp_valid), 32'(1 << i));
         chk("t2_rsp_data", 32'(rsp_data), 32'(t2_r[i]));
         tick();
      end
      chk("t2_idle", 32'(idle), 32'h1);
      $display("test2 round robin done");

      // 3: outstanding blocks requester 2
      req_a[23:16] = 8'h5A; req_b[23:16] = 8'h0F; req_valid = 4'b0100;
      #1 chk("t3_ready_first", 32'(req_ready), 32'h4);
      tick();
      for (int j = 1; j < 4; j++) begin
         chk("t3_ready_blocked", 32'(req_ready), 32'h0);
         tick();
      end
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("t3_rsp_data", 32'(rsp_data), 32'h55);
      chk("t3_ready_at_rsp", 32'(req_ready), 32'h0);
      tick();
      chk("t3_regrant", 32'(req_ready), 32'h4);
      tick(); req_valid = 4'h0;
      chk("t3_add_en", 32'(add_en), 32'h1);
      repeat (3) tick();
      chk("t3_rsp2_valid", 32'(rsp_valid), 32'h4);
      chk("t3_rsp2_data", 32'(rsp_data), 32'h55);
      tick();
      $display("test3 outstanding blocking done");

      // 4: pause for 6 cycles with two ops in flight
      req_a[7:0] = 8'h70;   req_b[7:0] = 8'h07;
      req_a[15:8] = 8'h0C;  req_b[15:8] = 8'hC0;
      req_a[31:24] = 8'hAA; req_b[31:24] = 8'h55;
      req_valid = 4'b0011;
      #1 chk("t4_ready0", 32'(req_ready), 32'h1);
      tick(); chk("t4_ready1", 32'(req_ready), 32'h2);
      tick(); req_valid = 4'b1001; pause = 1'b1;
      #1 chk("t4_pause_ready", 32'(req_ready), 32'h0);
      tick(); chk("t4_pause_ready", 32'(req_ready), 32'h0);
      tick();
      chk("t4_rsp0_valid", 32'(rsp_valid), 32'h1);
      chk("t4_rsp0_data", 32'(rsp_data), 32'h77);
      chk("t4_pause_ready", 32'(req_ready), 32'h0);
      tick();
      chk("t4_rsp1_valid", 32'(rsp_valid), 32'h2);
      chk("t4_rsp1_data", 32'(rsp_data), 32'hCC);
      chk("t4_pause_ready", 32'(req_ready), 32'h0);
      tick(); chk("t4_pause_ready", 32'(req_ready), 32'h0);
      tick(); chk("t4_pause_ready", 32'(req_ready), 32'h0);
      tick(); pause = 1'b0;
      #1 chk("t4_ptr_kept", 32'(req_ready), 32'h8);
      tick(); req_valid = 4'h0;
      chk("t4_add_a", 32'(add_a), 32'hAA);
      repeat (3) tick();
      chk("t4_rsp3_valid", 32'(rsp_valid), 32'h8);
      chk("t4_rsp3_data", 32'(rsp_data), 32'hFF);
      tick();
      $display("test4 pause done");

      // 5: reset with three ops in flight
      req_valid = 4'b0111;
      #1 chk("t5_ready0", 32'(req_ready), 32'h1);
      tick(); chk("t5_ready1", 32'(req_ready), 32'h2);
      tick(); chk("t5_ready2", 32'(req_ready), 32'h4);
      tick(); req_valid = 4'h0; rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      chk("t5_idle", 32'(idle), 32'h1);
      for (int k = 0; k < 6; k++) begin
         chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
         tick();
      end
      req_valid = 4'hF;
      #1 chk("t5_first_grant", 32'(req_ready), 32'h1);
      tick(); req_valid = 4'h0;
      repeat (6) tick();
      $display("test5 reset in flight done");

      // 6: statistics counter
`ifdef FP8_ARB_STATS_EN
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req_valid = 4'hF; hs = 0; cyc = 0;
      #1;
      while (hs < 70000 && cyc < 90000) begin
         if (|(req_valid & req_ready)) hs++;
         tick();
         cyc++;
      end
      req_valid = 4'h0;
      chk("t6_bound", 32'(hs), 32'd70000);
      chk("t6_stat_wrap", 32'(stat_ops), 32'd4464);
`else
      hs = 0; cyc = 0;
      chk("t6_stat_zero", 32'(stat_ops), 32'h0);
`endif
      $display("test6 stats done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fp8_add_arbiter.md
Name: fp8_add_arbiter

Overview:
- Shares one pipelined 8-bit floating-point adder (1 sign, 4 exponent, 3 mantissa bits) among NUM_REQ requesters.
- Each requester presents an operand pair over a valid/ready handshake.
- The block grants requesters round-robin, drives the adder inputs, and tracks in-flight operations with a tag pipeline matched to the adder latency.
- Each result is returned to the requester that issued it. The block sits between client logic and the fp8 adder instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ADDER_LAT, 3, cycles from add_en high to matching add_res; legal range >=1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  8*NUM_REQ  operand A; requester i occupies bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B; same packing as req_a.
- pause  in  1  blocks new grants; in-flight operations still complete.
- rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle long.
- rsp_data  out  8  result; valid only while any rsp_valid bit is high.
- add_a  out  8  adder operand A (registered).
- add_b  out  8  adder operand B (registered).
- add_en  out  1  adder issue strobe (registered).
- add_res  in  8  adder result.
- idle  out  1  high when nothing is outstanding and no issue is pending.
- stat_ops  out  16  issued-operation counter (see Optional Feature).

Behaviour:
- Reset, while rst_n is low at a clock edge:
  - req_ready=0, rsp_valid=0, rsp_data=0, add_a=0, add_b=0, add_en=0, idle=1, stat_ops=0.
  - Outstanding flags cleared, tag pipeline cleared, rr pointer = NUM_REQ-1 so requester 0 wins first.
  - Reset mid-operation discards all in-flight results; no rsp_valid is produced for them.
- Eligibility:
  - eligible[i] = req_valid[i] & ~outstanding[i] & ~pause.
  - Each requester may have at most one outstanding operation.
- Arbitration is combinational:
  - Search starts at index ptr+1 and wraps modulo NUM_REQ; the first eligible index wins.
  - req_ready[win]=1, all others 0. req_ready may depend on req_valid in the same cycle.
  - At most one handshake per cycle.
- On handshake (req_valid[i] & req_ready[i]) at edge T:
  - add_a <= req_a[i], add_b <= req_b[i], add_en <= 1 for exactly one cycle (T+1).
  - outstanding[i] <= 1, ptr <= i.
  - Tag {valid, index} enters the tag shift register.
  - If no handshake occurs, add_en <= 0 and add_a/add_b hold their values.
- Tag pipeline:
  - Depth ADDER_LAT, aligned so the tag exits in the cycle add_res is valid: T+1+ADDER_LAT.
  - In that cycle, rsp_valid[index]=1 and rsp_data=add_res, both combinational from the pipeline tail and add_res.
  - outstanding[index] clears at the end of that cycle.
- Same requester, response and new request in the same cycle: that requester is not eligible this cycle; the earliest regrant is the following cycle.
- Throughput: one issue per cycle across different requesters; one op per (ADDER_LAT+2) cycles for a single requester.
- pause:
  - Sampled combinationally. req_ready=0 while pause is high.
  - Responses continue. ptr is unchanged.
- idle = no outstanding flag set & add_en==0.
- No backpressure on responses: the client must accept rsp_valid when it is presented.

Optional Feature:
- Macro FP8_ARB_STATS_EN.
- Defined:
  - stat_ops increments by 1 on every handshake and wraps at 0xFFFF -> 0x0000.
  - Cleared by reset.
- Undefined: stat_ops is tied to 0 and no counter flops are built.

Decomposition:
- Shared package fp8_pkg holds:
  - FP8_W=8, FP8_EXP_W=4, FP8_MANT_W=3.
  - Field position constants.
  - fp8_t packed struct {sign, expo, mant}.
  - The max-requester constant (8).
- One sub-module, fp8_rr_pick: combinational round-robin picker.
  - Inputs: eligible vector and ptr.
  - Outputs: one-hot grant and encoded index.
- The tag pipeline and outstanding flags stay in the top module.

Test Plan:
- All tests use a bench stub adder that returns add_a^add_b after ADDER_LAT, so each result is unique per operand pair.
1. Single request: req 0 presents a=0x38, b=0x41 at cycle 5 -> add_en at cycle 6; rsp_valid=0001 and rsp_data=0x79 at cycle 9; idle returns to 1 at cycle 10.
2. All four requesters valid continuously from reset -> grants in order 0,1,2,3 on consecutive cycles; each rsp_valid bit arrives ADDER_LAT+1 cycles after its own grant.
3. Outstanding blocking: req 2 holds valid after its handshake -> req_ready[2]=0 until the cycle after rsp_valid[2], then it is regranted.
4. pause asserted for 6 cycles with 2 ops in flight -> no req_ready during pause; both responses still delivered with correct data; ptr unchanged.
5. Reset with 3 ops in flight -> zero rsp_valid pulses afterwards; idle=1 and the next grant goes to requester 0.
6. With FP8_ARB_STATS_EN defined, 70000 back-to-back ops -> stat_ops = 70000 mod 65536 = 4464. Undefined: stat_ops stays 0.
